// File: rtl/bch_31_decode_ctrl.sv
// BCH(31,21) double-error-correcting decoder controller over GF(2^5), p(x) = x^5 + x^2 + 1.
// A word is latched, its syndromes are registered, the error locator is solved in closed form,
// and a 31-cycle Chien search flips the located bits before the result is handed downstream.

// Combinational syndrome generator: s_j = r(alpha^j) for j = 1..4.
module bch_31_syndrome (
  input  logic [30:0] word,
  output logic [4:0]  s1,
  output logic [4:0]  s2,
  output logic [4:0]  s3,
  output logic [4:0]  s4
);

  function automatic logic [4:0] xtime(input logic [4:0] x);
    return {x[3:0], 1'b0} ^ (x[4] ? 5'b00101 : 5'b00000);
  endfunction

  // Horner-free evaluation: walk the bit positions, stepping alpha^(i*j) as we go.
  function automatic logic [4:0] eval_at(input logic [30:0] w, input int unsigned j);
    logic [4:0] p;
    logic [4:0] acc;
    p   = 5'd1;
    acc = 5'd0;
    for (int i = 0; i < 31; i++) begin
      if (w[i]) acc = acc ^ p;
      for (int k = 0; k < int'(j); k++) p = xtime(p);
    end
    return acc;
  endfunction

  assign s1 = eval_at(word, 1);
  assign s2 = eval_at(word, 2);
  assign s3 = eval_at(word, 3);
  assign s4 = eval_at(word, 4);

endmodule

module bch_31_decode_ctrl #(
  parameter bit EARLY_EXIT = 1'b1,
  parameter bit CHECK_S2S4 = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [30:0] out_word,
  output logic [1:0]  out_err_cnt,
  output logic        out_uncorr,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StSynd, StKey, StChien, StDone} state_e;

  localparam logic [4:0] AlphaInv1 = 5'h12;  // alpha^30
  localparam logic [4:0] AlphaInv2 = 5'h09;  // alpha^29

  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [8:0] p;
    p = 9'd0;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) p = p ^ (9'(a) << i);
    end
    for (int i = 8; i >= 5; i--) begin
      if (p[i]) p = p ^ (9'h025 << (i - 5));
    end
    return p[4:0];
  endfunction

  // a^-1 = a^30 = a^16 * a^8 * a^4 * a^2
  function automatic logic [4:0] gf_inv(input logic [4:0] a);
    logic [4:0] a2, a4, a8, a16;
    a2  = gf_mul(a, a);
    a4  = gf_mul(a2, a2);
    a8  = gf_mul(a4, a4);
    a16 = gf_mul(a8, a8);
    return gf_mul(gf_mul(a16, a8), gf_mul(a4, a2));
  endfunction

  state_e      state_q, state_d;
  logic [30:0] word_q, word_d;
  logic [30:0] corr_q, corr_d;
  logic [4:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
  logic [4:0]  t1_q, t1_d, t2_q, t2_d;
  logic [4:0]  pos_q, pos_d;
  logic [1:0]  deg_q, deg_d;
  logic [1:0]  root_q, root_d;
  logic        uncorr_q, uncorr_d;

  logic [4:0]  s1_c, s2_c, s3_c, s4_c;
  logic [4:0]  s1_sq, s1_cu, sigma2;
  logic        chk_fail, hit;
  logic [1:0]  root_inc, root_nxt;

  bch_31_syndrome u_synd (
    .word (word_q),
    .s1   (s1_c),
    .s2   (s2_c),
    .s3   (s3_c),
    .s4   (s4_c)
  );

  assign s1_sq    = gf_mul(s1_q, s1_q);
  assign s1_cu    = gf_mul(s1_sq, s1_q);
  assign sigma2   = gf_mul(s3_q ^ s1_cu, gf_inv(s1_q));
  assign chk_fail = CHECK_S2S4 && ((s2_q != s1_sq) || (s4_q != gf_mul(s2_q, s2_q)));
  // sigma(alpha^-i) = 1 + t1 + t2; zero means bit i is in error.
  assign hit      = ((5'd1 ^ t1_q ^ t2_q) == 5'd0);
  assign root_inc = (root_q == 2'd3) ? 2'd3 : root_q + 2'd1;
  assign root_nxt = hit ? root_inc : root_q;

  // Next-state and datapath updates for each decode phase.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    corr_d   = corr_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    s3_d     = s3_q;
    s4_d     = s4_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    pos_d    = pos_q;
    deg_d    = deg_q;
    root_d   = root_q;
    uncorr_d = uncorr_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          word_d   = in_word;
          corr_d   = '0;
          pos_d    = '0;
          root_d   = '0;
          deg_d    = '0;
          t1_d     = '0;
          t2_d     = '0;
          uncorr_d = 1'b0;
          state_d  = StSynd;
        end
      end
      StSynd: begin
        s1_d = s1_c;
        s2_d = s2_c;
        s3_d = s3_c;
        s4_d = s4_c;
        if (EARLY_EXIT && ((s1_c | s2_c | s3_c | s4_c) == 5'd0)) state_d = StDone;
        else                                                    state_d = StKey;
      end
      StKey: begin
        if (chk_fail || (s1_q == 5'd0 && s3_q != 5'd0)) begin
          uncorr_d = 1'b1;
          state_d  = StDone;
        end else begin
          state_d = StChien;
          if (s1_q == 5'd0) begin
            t1_d  = 5'd0;
            t2_d  = 5'd0;
            deg_d = 2'd0;
          end else if (s3_q == s1_cu) begin
            t1_d  = s1_q;
            t2_d  = 5'd0;
            deg_d = 2'd1;
          end else begin
            t1_d  = s1_q;
            t2_d  = sigma2;
            deg_d = 2'd2;
          end
        end
      end
      StChien: begin
        if (hit) corr_d = corr_q ^ (31'd1 << pos_q);
        root_d = root_nxt;
        t1_d   = gf_mul(t1_q, AlphaInv1);
        t2_d   = gf_mul(t2_q, AlphaInv2);
        pos_d  = pos_q + 5'd1;
        if (pos_q == 5'd30) begin
          uncorr_d = (root_nxt != deg_q);
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      word_q   <= '0;
      corr_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      s4_q     <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      pos_q    <= '0;
      deg_q    <= '0;
      root_q   <= '0;
      uncorr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      corr_q   <= corr_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      s4_q     <= s4_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      pos_q    <= pos_d;
      deg_q    <= deg_d;
      root_q   <= root_d;
      uncorr_q <= uncorr_d;
    end
  end

  // Outputs decode from state; in_ready is also gated by reset so it stays low while held.
  always_comb begin
    in_ready    = (state_q == StIdle) && rst_n;
    out_valid   = (state_q == StDone);
    busy        = (state_q != StIdle);
    out_word    = '0;
    out_err_cnt = '0;
    out_uncorr  = 1'b0;
    if (state_q == StDone) begin
      out_word    = uncorr_q ? word_q : (word_q ^ corr_q);
      out_err_cnt = uncorr_q ? 2'd0 : root_q;
      out_uncorr  = uncorr_q;
    end
  end

endmodule

// File: tb/tb_bch_31_decode_ctrl.sv
// Directed and random checks for bch_31_decode_ctrl using immediate assertions.
module tb_bch_31_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_word;
  logic [1:0]  out_err_cnt;
  logic        out_uncorr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bch_31_decode_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_err_cnt (out_err_cnt),
    .out_uncorr  (out_uncorr),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Non-systematic encoder: c(x) = m(x) * g(x), g(x) = 0x769 (octal 3551).
  function automatic logic [30:0] encode(input logic [20:0] m);
    logic [30:0] c;
    c = '0;
    for (int i = 0; i < 21; i++) begin
      if (m[i]) c = c ^ (31'h769 << i);
    end
    return c;
  endfunction

  // Present a word and return right after the accept edge.
  task automatic send(input logic [30:0] w);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency = index of the first edge after accept at which out_valid is sampled high.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic take_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drop_valid", 32'(out_valid), 32'd0);
    check("ready_after", 32'(in_ready), 32'd1);
  endtask

  task automatic expect_result(input string tag, input int exp_lat, input int lat,
                               input logic [30:0] w, input logic [1:0] cnt, input logic unc);
    if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_word"}, 32'(out_word), 32'(w));
    check({tag, "_cnt"}, 32'(out_err_cnt), 32'(cnt));
    check({tag, "_uncorr"}, 32'(out_uncorr), 32'(unc));
    check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [30:0] cw;
    logic [30:0] rx;
    logic [4:0]  p0, p1;
    int          k;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_word", 32'(out_word), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // All-zero word: early exit
    send(31'h0000_0000);
    wait_out(lat);
    expect_result("zero", 2, lat, 31'h0, 2'd0, 1'b0);
    take_out();

    // Single error at bit 5
    send(31'h0000_0020);
    wait_out(lat);
    expect_result("single", 34, lat, 31'h0, 2'd1, 1'b0);
    take_out();

    // Errors at bits 0 and 30, with a 5-cycle stall
    send(31'h4000_0001);
    wait_out(lat);
    expect_result("double", 34, lat, 31'h0, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_word", 32'(out_word), 32'd0);
      check("stall_cnt", 32'(out_err_cnt), 32'd2);
      check("stall_inrdy", 32'(in_ready), 32'd0);
    end
    take_out();

    // S1 = 0, S3 != 0: uncorrectable out of KEY
    send(31'h0000_0025);
    wait_out(lat);
    expect_result("uncorr", 3, lat, 31'h0000_0025, 2'd0, 1'b1);
    take_out();

    // Generator codeword with errors at bits 12 and 20
    send(31'h0000_0769 ^ 31'h0010_1000);
    wait_out(lat);
    expect_result("gen2", 34, lat, 31'h0000_0769, 2'd2, 1'b0);
    take_out();

    // Reset during Chien position 10
    send(31'h0000_0020);
    repeat (12) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_inrdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_inrdy", 32'(in_ready), 32'd1);
    send(31'h0000_0020);
    wait_out(lat);
    expect_result("post_rst", 34, lat, 31'h0, 2'd1, 1'b0);
    take_out();

    // Random codewords with 0..2 flips and random stalls
    for (int t = 0; t < 40; t++) begin
      cw = (t % 8 == 0) ? 31'h0 : encode(21'($urandom));
      k  = $urandom_range(0, 2);
      p0 = 5'($urandom_range(0, 30));
      p1 = 5'($urandom_range(0, 29));
      if (p1 >= p0) p1 = p1 + 5'd1;
      rx = cw;
      if (k >= 1) rx = rx ^ (31'd1 << p0);
      if (k == 2) rx = rx ^ (31'd1 << p1);
      send(rx);
      wait_out(lat);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("rnd_hold", 32'(out_valid), 32'd1);
      end
      expect_result("rnd", 0, lat, cw, 2'(k), 1'b0);
      take_out();
    end

    // No stray result after the stream
    repeat (3) @(negedge clk);
    check("end_idle_valid", 32'(out_valid), 32'd0);
    check("end_idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bch_31_decode_ctrl.md
Name: bch_31_decode_ctrl

Overview:
- Sequencing controller for the double-error-correcting BCH(31,21) decoder over GF(2^5), primitive polynomial x^5+x^2+1.
- Accepts one 31-bit received word per transaction and obtains S1..S4 from an internal bch_31_syndrome instance.
- Computes the error-locator polynomial, then runs a one-position-per-cycle Chien search and returns the corrected word with a status.
- Sits between the demodulator frame buffer and the payload extractor; both sides use valid/ready handshakes.

Parameters:
- EARLY_EXIT, 1: when 1, an all-zero syndrome skips KEY and CHIEN and goes straight to DONE.
- CHECK_S2S4, 1: when 1, S2 != S1^2 or S4 != S2^2 flags uncorrectable (hardware self-check).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  received word valid.
- in_ready  out  1  controller can accept a word.
- in_word  in  31  received word; bit i is the coefficient of x^i.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_word  out  31  corrected word, or the original word if uncorrectable.
- out_err_cnt  out  2  number of bits corrected (0..2).
- out_uncorr  out  1  word is uncorrectable.
- busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - One clock; rst_n is asynchronous and active-low: assertion forces IDLE immediately.
  - All outputs go to 0 on assertion, except in_ready, which is 1 in IDLE once rst_n deasserts.
  - Internal registers reset to 0.
  - Reset mid-operation abandons the word in flight with no output.
- States: IDLE, SYND, KEY, CHIEN, DONE.
- IDLE:
  - in_ready = 1.
  - in_valid & in_ready at edge T: in_word is latched into word_r and the state moves to SYND.
  - in_ready is 0 in every other state; there is no input buffering.
- SYND (1 cycle):
  - word_r drives the syndrome instance; S1..S4 are registered.
  - If all four syndromes are 0 and EARLY_EXIT=1: go to DONE with err_cnt=0 and uncorr=0.
  - If all four are 0 and EARLY_EXIT=0: go to KEY as normal.
  - Otherwise go to KEY.
- KEY (1 cycle):
  - S1=0 and S3=0: sigma1=sigma2=0, expected degree 0.
  - S1=0 and S3!=0: uncorr=1; skip CHIEN and go to DONE.
  - S1!=0 and S3=S1^3: sigma1=S1, sigma2=0, expected degree 1.
  - Otherwise: sigma1=S1, sigma2=(S3+S1^3)*S1^-1, expected degree 2.
  - The GF inverse is implemented as a 31-entry case table or as x^30.
  - If CHECK_S2S4=1 and the self-check fails: uncorr=1 and go to DONE.
- CHIEN (exactly 31 cycles, position i=0..30, counter 5 bits):
  - Term registers start with t1=sigma1, t2=sigma2.
  - Each cycle evaluates e = 1 ^ t1 ^ t2.
  - If e=0: flip bit i of corr_r and increment root_cnt.
  - Then update t1 *= alpha^-1 (= alpha^30) and t2 *= alpha^-2 (= alpha^29).
  - After i=30, go to DONE.
  - If root_cnt != expected degree: uncorr=1.
- DONE:
  - out_valid=1. If uncorr=0, out_word = word_r ^ corr_r; otherwise out_word = word_r.
  - out_err_cnt = root_cnt when uncorr=0, else 0.
  - Outputs hold stable while out_valid & !out_ready.
  - On out_valid & out_ready, go to IDLE; in_ready rises the next cycle, so there is no back-to-back accept in the same cycle.
- Latency from the accept edge T to out_valid:
  - Zero-syndrome with EARLY_EXIT=1: out_valid at T+2.
  - Early uncorrectable from KEY: out_valid at T+3.
  - Full path: out_valid at T+34.
- Arithmetic:
  - GF multiply is a combinational 5x5 polynomial multiply reduced mod x^5+x^2+1.
  - All field values are 5 bits.
  - root_cnt saturates at 3.

Test Plan:
- in_word=31'h0000_0000 with EARLY_EXIT=1 -> out_valid at T+2, out_word=0, err_cnt=0, uncorr=0.
- in_word=31'h0000_0020 (single error at bit 5) -> out_valid at T+34, out_word=0, err_cnt=1, uncorr=0.
- in_word=31'h4000_0001 (errors at bits 0 and 30) -> out_word=0, err_cnt=2, uncorr=0; hold out_ready=0 for 5 cycles and check the outputs stay stable and in_ready stays 0.
- in_word=31'h0000_0025 (bits 0,2,5, so S1=0 and S3!=0) -> out_valid at T+3, out_word=31'h0000_0025, err_cnt=0, uncorr=1.
- Pull rst_n low at cycle 10 of CHIEN -> out_valid and in_ready go to 0 immediately; after release, in_ready=1 and the next word 31'h0000_0020 decodes correctly.
- Random stream of valid codewords (all-zero plus encoder-generated words) with 0-2 random flips and random out_ready stalls -> every result matches the golden model; no lost or duplicated transactions.
